// File: rtl/pipe_clk_pkg.sv
// Shared definitions for the pipeline clock gater: FSM state encoding and a
// constant-evaluable ceil(log2) used to size internal counters.
package pipe_clk_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        TMO   = 2'd2
    } state_e;

    // Returns ceil(log2(v)); 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_clk_ctrl_gate.sv
// Single stage clock gating cell. Kept as its own module so it can later be
// swapped for a latch-based ICG without touching the controller.
module clk_gate_cell
    import pipe_clk_pkg::*;
(
    input  logic clk_in,
    input  logic en,
    input  logic force_en,
    output logic gclk
);

    // en only changes while clk_in is low, so the plain AND cannot glitch.
    assign gclk = clk_in & (en | force_en);

endmodule

// File: rtl/pipe_clk_ctrl.sv
// Per-stage pipeline clock gater: stall FSM with watchdog, enable shift chain
// that gates one further stage per cycle, and a saturating stall-cycle counter.
module pipe_clk_ctrl
    import pipe_clk_pkg::*;
#(
    parameter int N_STAGES  = 4,
    parameter int N_SRC     = 2,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 0
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic [N_SRC-1:0]    stall_req,
    input  logic [N_SRC-1:0]    src_mask,
    input  logic [N_STAGES-1:0] stage_force_en,
    input  logic                cnt_clr,
    output logic [N_STAGES-1:0] clk_stage,
    output logic [N_STAGES-1:0] stage_en,
    output logic                stalled,
    output logic                timeout_flag,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam int EP_W = (clog2(MAX_STALL + 1) < 1) ? 1 : clog2(MAX_STALL + 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [EP_W-1:0]     r_ep_cnt;
    logic [EP_W-1:0]     w_ep_nxt;
    logic [N_STAGES-1:0] r_en;
    logic [N_STAGES-1:0] w_en_nxt;
    logic                r_tmo;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_req_any;
    logic                w_target;
    logic                w_tmo_set;

    assign w_req_any = |(stall_req & ~src_mask);

    always_comb begin
        w_state_nxt = r_state;
        w_ep_nxt    = r_ep_cnt;
        w_target    = 1'b1;
        w_tmo_set   = 1'b0;
        case (r_state)
            RUN: begin
                if (w_req_any) begin
                    w_state_nxt = STALL;
                    w_ep_nxt    = EP_W'(1);
                    w_target    = 1'b0;
                end
            end
            STALL: begin
                w_target = 1'b0;
                w_ep_nxt = r_ep_cnt + EP_W'(1);
                // A request drop outranks the watchdog on the same edge.
                if (!w_req_any) begin
                    w_state_nxt = RUN;
                    w_target    = 1'b1;
                end else if ((MAX_STALL != 0) && (r_ep_cnt == EP_W'(MAX_STALL))) begin
                    w_state_nxt = TMO;
                    w_tmo_set   = 1'b1;
                    w_target    = 1'b1;
                end
            end
            TMO: begin
                if (!w_req_any) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
        if (w_state_nxt == RUN) begin
            w_ep_nxt = '0;
        end
    end

    always_comb begin
        w_en_nxt    = '1;
        w_en_nxt[0] = w_target;
        for (int unsigned i = 1; i < N_STAGES; i++) begin
            w_en_nxt[i] = r_en[i-1];
        end
    end

    always_ff @(negedge clk_in or negedge rst) begin
        if (!rst) begin
            r_state  <= RUN;
            r_ep_cnt <= '0;
            r_en     <= '1;
            r_tmo    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ep_cnt <= w_ep_nxt;
            r_en     <= w_en_nxt;
            if (cnt_clr) begin
                r_cnt <= '0;
                r_tmo <= 1'b0;
            end else begin
                if (!r_en[0] && !(&r_cnt)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_tmo_set) begin
                    r_tmo <= 1'b1;
                end
            end
        end
    end

    assign stage_en     = r_en;
    assign stalled      = (r_state == STALL);
    assign timeout_flag = r_tmo;
    assign stall_cnt    = r_cnt;

    for (genvar g = 0; g < N_STAGES; g++) begin : g_gate
        clk_gate_cell u_cell (
            .clk_in   (clk_in),
            .en       (r_en[g]),
            .force_en (stage_force_en[g]),
            .gclk     (clk_stage[g])
        );
    end

endmodule
